blimp_mem_arbiter: RTL and testbench

- Shares one memory request/response port between two requesters: requester 0 is instruction fetch, requester 1 is the data/load-store unit.
- Sits between the processor front-end/LSU and the memory interface of the Blimp core.
- Grants requests round-robin and forwards them through a one-entry output register.
- Tags the requester ID into the opaque MSB and uses that tag to steer each response back.
- Bounds outstanding requests per requester.

---
 rtl/blimp_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_blimp_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blimp_mem_arbiter.sv
// Two-way round-robin arbiter that shares one memory port between instruction fetch (0)
// and the load-store unit (1), tagging requests so responses can be routed back.
module blimp_mem_arbiter #(
  parameter int p_opaq_bits       = 8,
  parameter int p_max_outstanding = 4
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [1:0]                  req_val,
  output logic [1:0]                  req_rdy,
  input  logic [1:0][p_opaq_bits-1:0] req_opaque,
  input  logic [1:0]                  req_op,
  input  logic [1:0][31:0]            req_addr,
  input  logic [1:0][31:0]            req_data,

  output logic [1:0]                  resp_val,
  input  logic [1:0]                  resp_rdy,
  output logic [1:0][p_opaq_bits-1:0] resp_opaque,
  output logic [1:0]                  resp_op,
  output logic [1:0][31:0]            resp_data,

  output logic                        mem_req_val,
  input  logic                        mem_req_rdy,
  output logic [p_opaq_bits:0]        mem_req_opaque,
  output logic                        mem_req_op,
  output logic [31:0]                 mem_req_addr,
  output logic [31:0]                 mem_req_data,

  input  logic                        mem_resp_val,
  output logic                        mem_resp_rdy,
  input  logic [p_opaq_bits:0]        mem_resp_opaque,
  input  logic                        mem_resp_op,
  input  logic [31:0]                 mem_resp_data
);

  localparam int                    c_cnt_bits = $clog2(p_max_outstanding + 1);
  localparam logic [c_cnt_bits-1:0] c_cnt_max  = c_cnt_bits'(p_max_outstanding);
  localparam logic [c_cnt_bits-1:0] c_cnt_one  = c_cnt_bits'(1);

  logic [1:0][c_cnt_bits-1:0] cnt;
  logic                       ptr;
  logic                       reg_valid;
  logic [p_opaq_bits:0]       reg_opaque;
  logic                       reg_op;
  logic [31:0]                reg_addr;
  logic [31:0]                reg_data;

  logic                       can_load;
  logic [1:0]                 eligible;
  logic                       grant_any;
  logic                       grant_id;
  logic [1:0]                 req_fire;
  logic [1:0]                 resp_fire;
  logic                       resp_id;

  assign can_load    = !reg_valid || mem_req_rdy;
  assign eligible[0] = req_val[0] && (cnt[0] < c_cnt_max);
  assign eligible[1] = req_val[1] && (cnt[1] < c_cnt_max);

  // ptr names the preferred requester; fall back to the other one if it is idle or full
  always_comb begin
    grant_any = 1'b0;
    grant_id  = ptr;
    if (eligible[ptr]) begin
      grant_any = 1'b1;
      grant_id  = ptr;
    end else if (eligible[~ptr]) begin
      grant_any = 1'b1;
      grant_id  = ~ptr;
    end
  end

  assign req_rdy[0] = can_load && grant_any && !grant_id;
  assign req_rdy[1] = can_load && grant_any && grant_id;
  assign req_fire   = req_val & req_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_valid  <= 1'b0;
      reg_opaque <= '0;
      reg_op     <= 1'b0;
      reg_addr   <= '0;
      reg_data   <= '0;
    end else if (can_load) begin
      reg_valid <= grant_any;
      if (grant_any) begin
        reg_opaque <= {grant_id, req_opaque[grant_id]};
        reg_op     <= req_op[grant_id];
        reg_addr   <= req_addr[grant_id];
        reg_data   <= req_data[grant_id];
      end
    end
  end

  assign mem_req_val    = reg_valid;
  assign mem_req_opaque = reg_opaque;
  assign mem_req_op     = reg_op;
  assign mem_req_addr   = reg_addr;
  assign mem_req_data   = reg_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (|req_fire) begin
      ptr <= ~grant_id;
    end
  end

  // Responses are steered purely by the tag bit, so memory may reorder freely
  assign resp_id      = mem_resp_opaque[p_opaq_bits];
  assign mem_resp_rdy = resp_rdy[resp_id];

  always_comb begin
    resp_val          = '0;
    resp_val[resp_id] = mem_resp_val;
    for (int i = 0; i < 2; i++) begin
      resp_opaque[i] = mem_resp_opaque[p_opaq_bits-1:0];
      resp_op[i]     = mem_resp_op;
      resp_data[i]   = mem_resp_data;
    end
  end

  assign resp_fire[0] = resp_val[0] && resp_rdy[0] && (cnt[0] != '0);
  assign resp_fire[1] = resp_val[1] && resp_rdy[1] && (cnt[1] != '0);

  // A grant and a retired response in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_fire[i] && !resp_fire[i]) begin
          cnt[i] <= cnt[i] + c_cnt_one;
        end else if (!req_fire[i] && resp_fire[i]) begin
          cnt[i] <= cnt[i] - c_cnt_one;
        end
      end
    end
  end

endmodule

// File: tb/tb_blimp_mem_arbiter.sv
// Self-checking bench for blimp_mem_arbiter: directed scenarios followed by a random
// phase, all compared against a transaction-level reference model.
module tb_blimp_mem_arbiter;

  localparam int OB  = 8;
  localparam int MAX = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_val;
  logic [1:0]      req_rdy;
  logic [1:0][OB-1:0] req_opaque;
  logic [1:0]      req_op;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_data;
  logic [1:0]      resp_val;
  logic [1:0]      resp_rdy;
  logic [1:0][OB-1:0] resp_opaque;
  logic [1:0]      resp_op;
  logic [1:0][31:0] resp_data;
  logic            mem_req_val;
  logic            mem_req_rdy;
  logic [OB:0]     mem_req_opaque;
  logic            mem_req_op;
  logic [31:0]     mem_req_addr;
  logic [31:0]     mem_req_data;
  logic            mem_resp_val;
  logic            mem_resp_rdy;
  logic [OB:0]     mem_resp_opaque;
  logic            mem_resp_op;
  logic [31:0]     mem_resp_data;

  blimp_mem_arbiter #(.p_opaq_bits(OB), .p_max_outstanding(MAX)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_opaque(req_opaque), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_opaque(resp_opaque), .resp_op(resp_op),
    .resp_data(resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_opaque(mem_req_opaque),
    .mem_req_op(mem_req_op), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_opaque(mem_resp_opaque),
    .mem_resp_op(mem_resp_op), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OB:0]  opq;
    logic         op;
    logic [31:0]  addr;
    logic [31:0]  data;
  } mreq_t;

  int tests = 0;
  int fails = 0;

  // Reference model: outstanding totals, preferred requester, staged memory request
  int          out_cnt [2];
  int          pref;
  bit          m_valid;
  logic [OB:0] m_opq;
  logic        m_op;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  mreq_t       inflight[$];
  bit          resp_hs;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] rv, input logic mrr,
                               input logic [1:0] rrdy);
    rst         = r;
    req_val     = rv;
    mem_req_rdy = mrr;
    resp_rdy    = rrdy;
  endtask

  task automatic setReq(input int i, input logic [OB-1:0] opq, input logic op,
                        input logic [31:0] addr, input logic [31:0] data);
    req_opaque[i] = opq;
    req_op[i]     = op;
    req_addr[i]   = addr;
    req_data[i]   = data;
  endtask

  task automatic setResp(input logic v, input logic [OB:0] opq, input logic op,
                         input logic [31:0] data);
    mem_resp_val    = v;
    mem_resp_opaque = opq;
    mem_resp_op     = op;
    mem_resp_data   = data;
  endtask

  task automatic modelReset();
    out_cnt[0] = 0;
    out_cnt[1] = 0;
    pref       = 0;
    m_valid    = 0;
    inflight.delete();
  endtask

  // Check every output against the model at the falling edge, then advance the model one cycle
  task automatic step();
    bit         elig [2];
    bit         can;
    int         winner;
    int         rid;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    mreq_t      e;
    @(negedge clk);
    rid     = int'(mem_resp_opaque[OB]);
    exp_rv  = 2'b00;
    if (mem_resp_val) exp_rv[rid] = 1'b1;
    resp_hs = mem_resp_val && resp_rdy[rid];
    elig[0] = req_val[0] && (out_cnt[0] < MAX);
    elig[1] = req_val[1] && (out_cnt[1] < MAX);
    can     = !m_valid || mem_req_rdy;
    winner  = -1;
    if (can) begin
      if (elig[pref]) winner = pref;
      else if (elig[1-pref]) winner = 1 - pref;
    end
    exp_rdy = 2'b00;
    if (winner >= 0) exp_rdy[winner] = 1'b1;

    checkOutput("resp_val", resp_val, exp_rv);
    checkOutput("mem_resp_rdy", mem_resp_rdy, resp_rdy[rid]);
    if (mem_resp_val) begin
      checkOutput("resp_opaque", resp_opaque[rid], mem_resp_opaque[OB-1:0]);
      checkOutput("resp_op", resp_op[rid], mem_resp_op);
      checkOutput("resp_data", resp_data[rid], mem_resp_data);
    end

    if (rst) begin
      modelReset();
    end else begin
      checkOutput("req_rdy", req_rdy, exp_rdy);
      checkOutput("mem_req_val", mem_req_val, m_valid);
      if (m_valid) begin
        checkOutput("mem_req_opaque", mem_req_opaque, m_opq);
        checkOutput("mem_req_op", mem_req_op, m_op);
        checkOutput("mem_req_addr", mem_req_addr, m_addr);
        checkOutput("mem_req_data", mem_req_data, m_data);
      end
      if (m_valid && mem_req_rdy) begin
        e.opq = m_opq; e.op = m_op; e.addr = m_addr; e.data = m_data;
        inflight.push_back(e);
      end
      if (can) begin
        m_valid = (winner >= 0);
        if (winner >= 0) begin
          m_opq  = {winner[0], req_opaque[winner]};
          m_op   = req_op[winner];
          m_addr = req_addr[winner];
          m_data = req_data[winner];
          out_cnt[winner]++;
          pref = 1 - winner;
        end
      end
      if (resp_hs) begin
        tests++;
        if (out_cnt[rid] == 0) begin
          fails++;
          $display("[TB] FAIL illegal_resp: requester %0d has %0d outstanding, required >0", rid, out_cnt[rid]);
        end else begin
          out_cnt[rid]--;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 2'b00, 1'b1, 2'b11);
    step();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11);
  endtask

  initial begin
    int sel;
    modelReset();
    setReq(0, '0, 1'b0, '0, '0);
    setReq(1, '0, 1'b0, '0, '0);
    setResp(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 2'b00, 1'b1, 2'b11);
    step();
    step();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11);
    #1;
    checkOutput("reset_mem_req_val", mem_req_val, 1'b0);
    checkOutput("reset_resp_val", resp_val, 2'b00);

    // Single requester round trip
    setReq(0, 8'h05, 1'b0, 32'h100, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 2'b11);
    #1 checkOutput("single_rdy", req_rdy, 2'b01);
    step();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11);
    #1;
    checkOutput("single_mem_val", mem_req_val, 1'b1);
    checkOutput("single_mem_opq", mem_req_opaque, 9'h005);
    checkOutput("single_mem_addr", mem_req_addr, 32'h100);
    step();
    setResp(1'b1, 9'h005, 1'b0, 32'hDEADBEEF);
    #1;
    checkOutput("single_resp_val", resp_val, 2'b01);
    checkOutput("single_resp_opq", resp_opaque[0], 8'h05);
    checkOutput("single_resp_data", resp_data[0], 32'hDEADBEEF);
    step();
    setResp(1'b0, '0, 1'b0, '0);

    // Fairness: both requesting continuously
    doReset();
    setReq(0, 8'hA0, 1'b0, 32'h1000, 32'h0);
    setReq(1, 8'hB0, 1'b1, 32'h2000, 32'h55);
    applyStimulus(1'b0, 2'b11, 1'b1, 2'b11);
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput("fair_grant", req_rdy, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) checkOutput("fair_tag", mem_req_opaque[OB], ((k - 1) % 2));
      step();
    end
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11);
    step();

    // Outstanding limit on requester 1
    doReset();
    setReq(1, 8'h30, 1'b0, 32'h3000, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b1, 2'b11);
    for (int k = 0; k < 5; k++) begin
      #1 checkOutput("limit_req1", req_rdy[1], (k < 4));
      step();
    end
    setReq(0, 8'h31, 1'b0, 32'h3100, 32'h0);
    applyStimulus(1'b0, 2'b11, 1'b1, 2'b11);
    #1 checkOutput("limit_req0", req_rdy, 2'b01);
    step();
    applyStimulus(1'b0, 2'b10, 1'b1, 2'b11);
    setResp(1'b1, 9'h130, 1'b0, 32'h77);
    #1;
    checkOutput("limit_still_full", req_rdy, 2'b00);
    checkOutput("limit_resp_val", resp_val, 2'b10);
    step();
    setResp(1'b0, '0, 1'b0, '0);
    #1 checkOutput("limit_regrant", req_rdy, 2'b10);
    step();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11);
    step();

    // Backpressure holds the staged request
    doReset();
    setReq(0, 8'h40, 1'b0, 32'h200, 32'h0);
    setReq(1, 8'h41, 1'b1, 32'h300, 32'h9);
    applyStimulus(1'b0, 2'b01, 1'b1, 2'b11);
    step();
    applyStimulus(1'b0, 2'b11, 1'b0, 2'b11);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("bp_addr", mem_req_addr, 32'h200);
      checkOutput("bp_rdy", req_rdy, 2'b00);
      step();
    end
    applyStimulus(1'b0, 2'b11, 1'b1, 2'b11);
    #1;
    checkOutput("bp_release_addr", mem_req_addr, 32'h200);
    checkOutput("bp_release_rdy", req_rdy, 2'b10);
    step();
    #1;
    checkOutput("bp_flow_addr", mem_req_addr, 32'h300);
    checkOutput("bp_flow_rdy", req_rdy, 2'b01);
    step();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11);
    step();

    // Out-of-order responses and response backpressure
    doReset();
    setReq(0, 8'h11, 1'b0, 32'h500, 32'h0);
    setReq(1, 8'h22, 1'b1, 32'h600, 32'hAB);
    applyStimulus(1'b0, 2'b01, 1'b1, 2'b11);
    step();
    applyStimulus(1'b0, 2'b10, 1'b1, 2'b11);
    step();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11);
    step();
    setResp(1'b1, 9'h122, 1'b1, 32'hC0FFEE00);
    #1;
    checkOutput("ooo_first_val", resp_val, 2'b10);
    checkOutput("ooo_first_opq", resp_opaque[1], 8'h22);
    step();
    setResp(1'b1, 9'h011, 1'b0, 32'h12345678);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b10);
    for (int k = 0; k < 2; k++) begin
      #1;
      checkOutput("ooo_hold_rdy", mem_resp_rdy, 1'b0);
      checkOutput("ooo_hold_val", resp_val, 2'b01);
      step();
    end
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11);
    #1;
    checkOutput("ooo_release_rdy", mem_resp_rdy, 1'b1);
    checkOutput("ooo_second_opq", resp_opaque[0], 8'h11);
    step();
    setResp(1'b0, '0, 1'b0, '0);

    // Reset with a staged request and two outstanding
    doReset();
    setReq(0, 8'h60, 1'b0, 32'h700, 32'h0);
    setReq(1, 8'h61, 1'b0, 32'h800, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 2'b11);
    step();
    step();
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b11);
    #1 checkOutput("mid_pre_val", mem_req_val, 1'b1);
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b11);
    step();
    applyStimulus(1'b0, 2'b11, 1'b1, 2'b11);
    #1;
    checkOutput("mid_post_val", mem_req_val, 1'b0);
    checkOutput("mid_post_grant", req_rdy, 2'b01);
    step();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11);
    step();

    // Random traffic with an any-order memory
    doReset();
    for (int n = 0; n < 400; n++) begin
      setReq(0, 8'($urandom), 1'($urandom), $urandom, $urandom);
      setReq(1, 8'($urandom), 1'($urandom), $urandom, $urandom);
      applyStimulus(1'b0, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)));
      sel = -1;
      if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, inflight.size() - 1);
        setResp(1'b1, inflight[sel].opq, 1'($urandom), $urandom);
      end else begin
        setResp(1'b0, 9'($urandom), 1'($urandom), $urandom);
      end
      step();
      if (sel >= 0 && resp_hs) inflight.delete(sel);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
